sam_core: RTL and testbench

Parametrised, synthesizable successor to the simple accumulator machine. A single-accumulator CPU with a registered fetch/decode/memory/execute FSM, an 8-opcode ISA (LOAD, STORE, ADD, SUB, BRN, BRZ, JMP, HALT) and a sticky signed-overflow flag. All memory traffic goes through one REQUEST/WAIT handshake port. It sits between the system clock/reset and the shared memory model, replacing the hand-wired control-word datapath.

---
 rtl/sam_core.sv | 134 +++++++++++++
 tb/tb_sam_core.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sam_core.sv
// sam_core: single-accumulator CPU with a FETCH/DECODE/DATA/HALT FSM behind one request/wait memory port
module sam_core #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 12,
  parameter int                 PC_STEP  = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  input  logic              mem_wait,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir,
  output logic              ovf,
  output logic              halted
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_DATA, S_HALT} state_t;
  localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_BRN = 3'd4, OP_BRZ = 3'd5, OP_JMP = 3'd6, OP_HALT = 3'd7;
  localparam int MSB = DATA_W - 1;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0] ac_q, ac_d, ir_q, ir_d, wdata_q, wdata_d;
  logic ovf_q, ovf_d, req_q, req_d, rw_q, rw_d;

  logic [2:0] op;
  logic [ADDR_W-1:0] opa, pc_inc;
  logic [DATA_W-1:0] sum, dif;
  logic taken, add_v, sub_v;

  assign op     = ir_q[MSB -: 3];
  assign opa    = ir_q[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);
  assign taken  = (op == OP_JMP) || (op == OP_BRN && ac_q[MSB]) || (op == OP_BRZ && ac_q == '0);
  assign sum    = ac_q + mem_rdata;
  assign dif    = ac_q - mem_rdata;
  assign add_v  = (ac_q[MSB] == mem_rdata[MSB]) && (sum[MSB] != ac_q[MSB]);
  assign sub_v  = (ac_q[MSB] != mem_rdata[MSB]) && (dif[MSB] != ac_q[MSB]);

  // Bus registers are loaded on the edge entering a state, so the request is
  // already presented in the first cycle of DATA and of a post-branch FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    ovf_d   = ovf_q;
    req_d   = req_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          rw_d   = 1'b1;
          addr_d = pc_q;
        end else if (!mem_wait) begin
          ir_d    = mem_rdata;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else if (op[2]) begin
          pc_d    = taken ? opa : pc_inc;
          state_d = S_FETCH;
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = taken ? opa : pc_inc;
        end else begin
          pc_d    = pc_inc;
          state_d = S_DATA;
          req_d   = 1'b1;
          rw_d    = op != OP_STORE;
          addr_d  = opa;
          wdata_d = ac_q;
        end
      end
      S_DATA: begin
        if (!mem_wait) begin
          ac_d    = op == OP_LOAD ? mem_rdata : op == OP_ADD ? sum : op == OP_SUB ? dif : ac_q;
          ovf_d   = ovf_q | (op == OP_ADD && add_v) | (op == OP_SUB && sub_v);
          state_d = S_FETCH;
          rw_d    = 1'b1;
          addr_d  = pc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ac_q    <= '0;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_req   = req_q;
  assign mem_rw    = rw_q;
  assign pc        = pc_q;
  assign ac        = ac_q;
  assign ir        = ir_q;
  assign ovf       = ovf_q;
  assign halted    = state_q == S_HALT;
endmodule

// File: tb/tb_sam_core.sv
// tb_sam_core: directed programs against an instruction-level model of the accumulator CPU
module tb_sam_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // main core: 16-bit data, 12-bit address, reset PC 0
  logic rst_n = 1'b0;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, ac, ir;
  logic mem_req, mem_rw, mem_wait, ovf, halted;
  logic force_wait = 1'b0;
  int nwait = 0, wc = 0, wr_cnt = 0;
  logic [15:0] mem0 [0:2047];
  logic [15:0] mm [0:2047];

  sam_core u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_wait(mem_wait), .pc(pc), .ac(ac), .ir(ir),
    .ovf(ovf), .halted(halted)
  );

  assign mem_rdata = mem0[mem_addr[11:1]];
  assign mem_wait  = force_wait || (wc < nwait);

  always @(posedge clk) begin
    wc <= (mem_req && mem_wait) ? wc + 1 : 0;
    if (mem_req && !mem_wait && !mem_rw) begin
      mem0[mem_addr[11:1]] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  // second core: 24-bit data, 16-bit address, reset PC near the top of memory
  logic rstb_n = 1'b0;
  logic [15:0] b_addr, b_pc;
  logic [23:0] b_wdata, b_rdata, b_ac, b_ir;
  logic b_req, b_rw, b_ovf, b_halted;
  logic b_wait = 1'b0;
  logic [23:0] mem1 [0:32767];
  logic [15:0] blog [$];

  sam_core #(.DATA_W(24), .ADDR_W(16), .PC_STEP(2), .RESET_PC(16'hFFFE)) u_dut_b (
    .clk(clk), .rst_n(rstb_n), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_req(b_req), .mem_rw(b_rw), .mem_wait(b_wait), .pc(b_pc), .ac(b_ac), .ir(b_ir),
    .ovf(b_ovf), .halted(b_halted)
  );

  assign b_rdata = mem1[b_addr[15:1]];

  always @(posedge clk)
    if (b_req && !b_wait && !b_rw) mem1[b_addr[15:1]] = b_wdata;

  always @(negedge clk)
    if (rstb_n && b_req && !b_wait && b_rw) blog.push_back(b_addr);

  // instruction-level model: predicts each completed access and the architectural
  // state visible at every instruction boundary
  logic chk_en = 1'b0;
  int mr_req = 0, mr_seen = 0;
  int cyc = 0, m_phase = 0, m_last = -1, m_exp = 0, s = 0;
  logic [11:0] m_pc = '0, m_a = '0, p_addr = '0;
  logic [15:0] m_ac = '0, m_ir = '0, rdv = '0, p_wd = '0;
  logic [2:0] m_op = '0;
  logic m_ovf = 1'b0, p_req = 1'b0, p_done = 1'b0, p_rw = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mr_req != mr_seen) begin
      mr_seen = mr_req;
      m_pc = '0; m_ac = '0; m_ovf = 1'b0; m_ir = '0; m_phase = 0; m_last = -1;
      p_req = 1'b0; p_done = 1'b0;
    end
    if (chk_en) begin
      if (mem_req && p_req && !p_done) begin
        chk("hold_addr", 32'(mem_addr), 32'(p_addr));
        chk("hold_rw", 32'(mem_rw), 32'(p_rw));
        chk("hold_wdata", 32'(mem_wdata), 32'(p_wd));
      end
      if (halted) chk("halt_noreq", 32'(mem_req), 0);
      if (mem_req && !mem_wait) begin
        if (m_phase == 0) begin
          chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
          chk("fetch_rw", 32'(mem_rw), 1);
          chk("arch_pc", 32'(pc), 32'(m_pc));
          chk("arch_ac", 32'(ac), 32'(m_ac));
          chk("arch_ovf", 32'(ovf), 32'(m_ovf));
          chk("arch_ir", 32'(ir), 32'(m_ir));
          if (m_last >= 0) chk("latency", 32'(cyc - m_last), 32'(m_exp));
          m_last = cyc;
          m_ir = mm[m_pc[11:1]];
          m_op = m_ir[15:13];
          m_a  = m_ir[11:0];
          if (m_op == 3'd7) m_phase = 2;
          else if (m_op[2]) begin
            m_pc  = (m_op == 3'd6 || (m_op == 3'd4 && m_ac[15]) || (m_op == 3'd5 && m_ac == 16'h0)) ? m_a : m_pc + 12'd2;
            m_exp = 2 + nwait;
          end else begin
            m_pc    = m_pc + 12'd2;
            m_phase = 1;
            m_exp   = 3 + 2 * nwait;
          end
        end else if (m_phase == 1) begin
          chk("data_addr", 32'(mem_addr), 32'(m_a));
          chk("data_rw", 32'(mem_rw), (m_op == 3'd1) ? 0 : 1);
          if (m_op == 3'd1) begin
            chk("data_wdata", 32'(mem_wdata), 32'(m_ac));
            mm[m_a[11:1]] = m_ac;
          end else begin
            rdv = mm[m_a[11:1]];
            if (m_op == 3'd0) m_ac = rdv;
            else begin
              s = (m_op == 3'd2) ? int'($signed(m_ac)) + int'($signed(rdv))
                                 : int'($signed(m_ac)) - int'($signed(rdv));
              if (s > 32767 || s < -32768) m_ovf = 1'b1;
              m_ac = s[15:0];
            end
          end
          m_phase = 0;
        end
      end
      p_req  = mem_req;
      p_addr = mem_addr;
      p_rw   = mem_rw;
      p_wd   = mem_wdata;
      p_done = mem_req && !mem_wait;
    end
  end

  task automatic clr();
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = '0;
      mm[i]   = '0;
    end
  endtask

  task automatic ld(input logic [11:0] a, input logic [15:0] d);
    mem0[a[11:1]] = d;
    mm[a[11:1]]   = d;
  endtask

  task automatic hold_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    mr_req = mr_req + 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_run(input int maxc, output int cy, output logic [11:0] fa);
    int st = -1;
    int n;
    fa = '0;
    chk_en = 1'b1;
    rst_n  = 1'b1;
    for (n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (st < 0 && mem_req) begin
        st = n;
        fa = mem_addr;
      end
      if (halted) break;
    end
    chk("halt_reached", 32'(halted), 1);
    cy = n - st;
  endtask

  task automatic load_sum_prog();
    clr();
    ld(12'h000, 16'h0100); ld(12'h002, 16'h4102); ld(12'h004, 16'h2104); ld(12'h006, 16'hE000);
    ld(12'h100, 16'h0005); ld(12'h102, 16'h0007);
  endtask

  initial begin
    int c;
    logic [11:0] fa;
    logic [15:0] exp_log [6];
    exp_log = '{16'hFFFE, 16'h0100, 16'h0000, 16'h0102, 16'h0002, 16'h0040};

    // load/add/store/halt with zero wait, plus reset values
    load_sum_prog();
    nwait = 0;
    hold_reset();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_rw", 32'(mem_rw), 1);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ac", 32'(ac), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_halted", 32'(halted), 0);
    release_run(200, c, fa);
    chk("t1_first_fetch", 32'(fa), 0);
    chk("t1_cycles", 32'(c), 11);
    chk("t1_mem104", 32'(mem0[12'h104 >> 1]), 32'h000C);
    chk("t1_ac", 32'(ac), 32'h000C);
    chk("t1_pc", 32'(pc), 32'h006);
    chk("t1_ovf", 32'(ovf), 0);

    // overflow, BRN taken, SUB keeps sticky ovf, BRZ taken
    clr();
    ld(12'h000, 16'h0100); ld(12'h002, 16'h4102); ld(12'h004, 16'h8040); ld(12'h006, 16'hE000);
    ld(12'h040, 16'h6104); ld(12'h042, 16'hA080); ld(12'h044, 16'hE000); ld(12'h080, 16'hE000);
    ld(12'h100, 16'h7FFF); ld(12'h102, 16'h0001); ld(12'h104, 16'h8000);
    hold_reset();
    release_run(200, c, fa);
    chk("t2_cycles", 32'(c), 15);
    chk("t2_ac", 32'(ac), 0);
    chk("t2_ovf", 32'(ovf), 1);
    chk("t2_pc", 32'(pc), 32'h080);

    // three wait cycles on every access
    load_sum_prog();
    nwait = 3;
    hold_reset();
    release_run(400, c, fa);
    chk("t3_cycles", 32'(c), 32);
    chk("t3_mem104", 32'(mem0[12'h104 >> 1]), 32'h000C);
    chk("t3_ac", 32'(ac), 32'h000C);
    nwait = 0;

    // PC wrap from 0xFFE to 0x000
    clr();
    ld(12'h000, 16'hAFFE); ld(12'hFFE, 16'h0100); ld(12'h002, 16'hE000); ld(12'h100, 16'h0001);
    hold_reset();
    release_run(200, c, fa);
    chk("t4_cycles", 32'(c), 9);
    chk("t4_pc", 32'(pc), 32'h002);
    chk("t4_ac", 32'(ac), 1);

    // reset during a stalled STORE
    clr();
    ld(12'h000, 16'h0100); ld(12'h002, 16'h2104); ld(12'h004, 16'hE000);
    ld(12'h100, 16'h1234); ld(12'h104, 16'hAAAA);
    hold_reset();
    chk_en = 1'b0;
    wr_cnt = 0;
    rst_n  = 1'b1;
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req && !mem_rw) break;
    end
    force_wait = 1'b1;
    chk("t5_store_seen", (c < 30) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    chk("t5_stall_addr", 32'(mem_addr), 32'h104);
    chk("t5_stall_wdata", 32'(mem_wdata), 32'h1234);
    chk("t5_stall_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_drop", 32'(mem_req), 0);
    chk("t5_rst_addr", 32'(mem_addr), 0);
    chk("t5_rst_rw", 32'(mem_rw), 1);
    chk("t5_rst_wdata", 32'(mem_wdata), 0);
    chk("t5_rst_pc", 32'(pc), 0);
    chk("t5_rst_ac", 32'(ac), 0);
    chk("t5_rst_ir", 32'(ir), 0);
    chk("t5_no_write", 32'(wr_cnt), 0);
    chk("t5_mem_intact", 32'(mem0[12'h104 >> 1]), 32'hAAAA);
    force_wait = 1'b0;
    hold_reset();
    release_run(200, c, fa);
    chk("t5_refetch_addr", 32'(fa), 0);
    chk("t5_mem104", 32'(mem0[12'h104 >> 1]), 32'h1234);
    chk("t5_one_write", 32'(wr_cnt), 1);

    // 24-bit core: wrap from reset PC, SUB borrow, BRN taken
    for (int i = 0; i < 32768; i++) mem1[i] = '0;
    mem1[16'hFFFE >> 1] = 24'h000100;
    mem1[16'h0000 >> 1] = 24'h600102;
    mem1[16'h0002 >> 1] = 24'h800040;
    mem1[16'h0004 >> 1] = 24'hE00000;
    mem1[16'h0040 >> 1] = 24'hE00000;
    mem1[16'h0102 >> 1] = 24'h000001;
    blog.delete();
    @(negedge clk);
    chk("b_rst_pc", 32'(b_pc), 32'hFFFE);
    rstb_n = 1'b1;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b_halted) break;
    end
    chk("b_halted", 32'(b_halted), 1);
    chk("b_ac", 32'(b_ac), 32'hFFFFFF);
    chk("b_ovf", 32'(b_ovf), 0);
    chk("b_pc", 32'(b_pc), 32'h0040);
    chk("b_log_len", 32'(blog.size()), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b_log%0d", i), (i < blog.size()) ? 32'(blog[i]) : 32'hFFFFFFFF, 32'(exp_log[i]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
